// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared types and default sizes for the sprite palette RAM
package palette_pkg;

    localparam int DEF_INDEX_W   = 4;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_COLOR_W   = 4;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] red;
        logic [DEF_COLOR_W-1:0] green;
        logic [DEF_COLOR_W-1:0] blue;
    } rgb_t;

    typedef struct packed {
        rgb_t rgb;
        logic transp;
    } palette_entry_t;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } pal_state_t;

endpackage

// File: rtl/sprite_palette_ram_if.sv
// rtl/sprite_palette_ram_if.sv - lookup, pixel and write-port bundle of the sprite palette RAM
interface sprite_palette_ram_if #(
    parameter int INDEX_W   = palette_pkg::DEF_INDEX_W,
    parameter int NUM_BANKS = palette_pkg::DEF_NUM_BANKS,
    parameter int COLOR_W   = palette_pkg::DEF_COLOR_W
);
    // A single-bank palette still carries a 1-bit bank field; the RAM ignores it.
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                   rd_valid;
    logic [BANK_W-1:0]      rd_bank;
    logic [INDEX_W-1:0]     rd_index;
    logic                   pix_valid;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   transparent;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_index;
    logic [3*COLOR_W-1:0]   wr_rgb;
    logic                   wr_transp;
    logic                   busy;

    modport master (
        output rd_valid, rd_bank, rd_index, wr_valid, wr_bank, wr_index, wr_rgb, wr_transp,
        input  pix_valid, red, green, blue, transparent, wr_ready, busy
    );

    modport slave (
        input  rd_valid, rd_bank, rd_index, wr_valid, wr_bank, wr_index, wr_rgb, wr_transp,
        output pix_valid, red, green, blue, transparent, wr_ready, busy
    );

endinterface

// File: rtl/palette_store.sv
// rtl/palette_store.sv - simple dual-port RAM, one write port, registered read-first read port
module palette_store #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_palette_ram.sv
// rtl/sprite_palette_ram.sv - multi-bank writable sprite palette with power-up self-clear
module sprite_palette_ram
    import palette_pkg::*;
#(
    parameter int INDEX_W   = DEF_INDEX_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int COLOR_W   = DEF_COLOR_W
) (
    input  logic                clk,
    input  logic                rst,
    sprite_palette_ram_if.slave bus
);

    localparam int LOG_B  = $clog2(NUM_BANKS);
    localparam int ADDR_W = LOG_B + INDEX_W;
    localparam int DATA_W = 3 * COLOR_W + 1;

    pal_state_t        state;
    logic [ADDR_W:0]   clr_cnt;
    logic              wr_ready_q;
    logic              busy_q;
    logic              s1_valid;
    logic              pix_valid_q;
    logic [DATA_W-1:0] pix_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // Size casts drop the bank bit when there is only one bank.
    always_comb begin
        raddr = ADDR_W'({bus.rd_bank, bus.rd_index});
        we    = 1'b0;
        waddr = clr_cnt[ADDR_W-1:0];
        wdata = {{(3*COLOR_W){1'b0}}, 1'b1};
        if (state == CLEAR) begin
            we = !clr_cnt[ADDR_W];
        end else begin
            we    = bus.wr_valid && wr_ready_q;
            waddr = ADDR_W'({bus.wr_bank, bus.wr_index});
            wdata = {bus.wr_rgb, bus.wr_transp};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt[ADDR_W]) begin
                        state      <= IDLE;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
                    end
                end
                IDLE: begin
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // The RAM's read register is the first lookup stage: it samples the address
    // in the same edge a write lands, so a same-cycle write is seen only next time.
    palette_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
        end else begin
            s1_valid    <= bus.rd_valid;
            pix_valid_q <= s1_valid;
            pix_q       <= rdata;
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign {bus.red, bus.green, bus.blue, bus.transparent} = pix_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/sprite_palette_ram.md
# sprite_palette_ram

Writable, multi-bank colour palette for the sprite pipeline. It replaces fixed per-sprite palette ROMs with one RAM that holds NUM_BANKS palettes of 2^INDEX_W entries each. Sprite pixel indices go in, registered RGB plus a transparency flag come out two cycles later. Software or a loader FSM rewrites entries through a valid/ready write port. After reset the block self-clears every entry before it accepts writes.

## Interface
Parameters:
- INDEX_W, 4: pixel index width; each bank holds 2^INDEX_W entries.
- NUM_BANKS, 4: number of palettes; must be a power of two, at least 1.
- COLOR_W, 4: bits per colour channel.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- rd_valid  in  1  pixel lookup request this cycle.
- rd_bank  in  $clog2(NUM_BANKS)  palette bank select.
- rd_index  in  INDEX_W  pixel colour index.
- pix_valid  out  1  RGB outputs valid (rd_valid delayed 2 cycles).
- red, green, blue  out  COLOR_W each  looked-up colour.
- transparent  out  1  entry is marked transparent.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_bank  in  $clog2(NUM_BANKS)  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*COLOR_W  {red, green, blue}.
- wr_transp  in  1  transparency bit for the entry.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: CLEAR and IDLE. Reset forces CLEAR with the clear address at 0.
- CLEAR:
  - Writes one entry per cycle. Each entry is set to RGB 0 and transparent=1, except index 0 of every bank, which is set to transparent=1 as well (all entries start transparent black).
  - The clear address walks bank-major over all NUM_BANKS*2^INDEX_W entries.
  - After the last entry is written, the FSM goes to IDLE on the next edge.
  - busy=1 and wr_ready=0 throughout CLEAR.
- IDLE:
  - wr_ready=1 and busy=0.
  - An accepted write updates the entry at the next clock edge.
- Lookup pipeline, two stages:
  - S1 registers rd_valid, rd_bank and rd_index.
  - S2 reads the RAM and registers RGB, transparent and pix_valid.
- Lookups are serviced in CLEAR as well. They return whatever the entry currently holds (cleared or not yet cleared).
- Simultaneous read and write to the same entry in the same cycle: the lookup returns the old value. A lookup issued one cycle later returns the new value.
- pix_valid=0 cycles still update red, green, blue and transparent. Downstream must gate on pix_valid.

## Timing
- Reset values: pix_valid=0, red=green=blue=0, transparent=0, wr_ready=0, busy=1. Pipeline valid bits are cleared.
- Lookup latency: rd_valid at edge t gives pix_valid at edge t+2. Throughput is one lookup per cycle, with no stalls.
- Clear duration: exactly NUM_BANKS*2^INDEX_W cycles after Reset deasserts. wr_ready rises on the following cycle (64 cycles, then ready at cycle 65, for the defaults).
- Write handshake:
  - wr_ready does not depend combinationally on wr_valid.
  - Requests with wr_valid && !wr_ready are ignored, not queued.
- Reset asserted mid-clear or mid-lookup:
  - Outputs return to their reset values immediately.
  - In-flight lookups are dropped.
  - The clear restarts from address 0.
- Address widths: bank and index are concatenated as {bank, index} into a $clog2(NUM_BANKS)+INDEX_W bit RAM address. There is no arithmetic overflow; the clear counter is one bit wider to detect completion.

## Structure
- Package palette_pkg:
  - rgb_t packed struct {red, green, blue} of COLOR_W bits.
  - palette_entry_t {rgb_t rgb; logic transp}.
  - State enum pal_state_t {CLEAR, IDLE}.
  - Default-parameter constants.
- Sub-module palette_store:
  - One write port, one registered read port, read-first behaviour.
  - Sized for inference as on-chip block RAM.
  - The top level muxes the write port between the clear FSM and the external write port.

## Test plan
- Reset, then Reset deasserted with defaults: busy=1 for 64 cycles, wr_ready=1 at cycle 65. A lookup of bank 2 index 5 then returns RGB 000, transparent=1.
- Write bank 1 index 3 = RGB F76, transp=0. A lookup of bank 1 index 3 one cycle later returns F76, transparent=0, with pix_valid exactly 2 cycles after rd_valid.
- Back-to-back lookups on 8 consecutive cycles across all banks: 8 consecutive pix_valid cycles, in order, with correct colours.
- Same-cycle write A0E to bank 0 index 6 and lookup of bank 0 index 6: the old value is returned. A lookup the next cycle returns A0E.
- wr_valid held during CLEAR: no entry changes. Writes issued with wr_ready=0 leave the bank content all-transparent-black.
- Reset pulsed 10 cycles into CLEAR: outputs drop to their reset values, busy stays 1, and wr_ready rises 65 cycles after the second deassertion.
